// File: rtl/busio_target_if.sv
// Bus-side signal bundle for the SYNC/DIN/DOUT/WTBT/RPLY handshake.
// The initiator uses the master modport and the responder uses the slave modport.
interface busio_target_if;
  logic        SYNC;
  logic        DIN;
  logic        DOUT;
  logic        WTBT;
  logic [15:0] addr_i;
  logic [15:0] data_i;
  logic [15:0] data_o;
  logic        data_oe;
  logic        RPLY;
  logic        berr;

  modport master (
    output SYNC, DIN, DOUT, WTBT, addr_i, data_i,
    input  data_o, data_oe, RPLY, berr
  );

  modport slave (
    input  SYNC, DIN, DOUT, WTBT, addr_i, data_i,
    output data_o, data_oe, RPLY, berr
  );
endinterface

// File: rtl/busio_target.sv
// Bus responder: decodes an address window, runs a local memory cycle and answers with RPLY.
// Define BUSIO_TARGET_TMO_EN to add a memory-ack timeout that ends the cycle with a berr pulse.
//
// state  | meaning
// S_IDLE | waiting for a SYNC rising edge that hits the window
// S_WAIT | counting wait states; writes also wait here for DOUT
// S_MEM  | strobe active, waiting for mem_ack
// S_RPLY | RPLY asserted until the initiator releases SYNC/DIN/DOUT
// S_ERR  | memory timed out, no RPLY; waiting for SYNC to fall
module busio_target #(
  parameter logic [15:0] BASE    = 16'o100000,
  parameter logic [15:0] MASK    = 16'o077777,
  parameter int          WAIT    = 0,
  parameter int          TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  busio_target_if.slave bus,
  output logic [14:0]   mem_addr,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_MEM  = 3'd2,
    S_RPLY = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic       sync_q, rd_q, abort_q, berr_q;
  logic [3:0] wait_cnt;
  logic       hit, start, issue, done, tmo_hit;

  if (WAIT < 0 || WAIT > 15) begin : g_chk_wait
    $error("busio_target: WAIT must be within 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_chk_tmo
    $error("busio_target: TIMEOUT must be within 1..255");
  end

  assign hit = ((bus.addr_i & ~MASK) == BASE);

`ifdef BUSIO_TARGET_TMO_EN
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (ce) begin
      if (issue)
        tmo_cnt <= 8'(TIMEOUT);
      else if (state == S_MEM && tmo_cnt != 8'd0)
        tmo_cnt <= tmo_cnt - 8'd1;
    end
  end

  // Terminal count is reached on the ce that would take the counter to zero.
  assign tmo_hit = (state == S_MEM) && !mem_ack && (tmo_cnt <= 8'd1);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.SYNC && !sync_q && hit) begin
          state_nxt = S_WAIT;
          start     = 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.SYNC) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == 4'd0 && (rd_q || bus.DOUT)) begin
          state_nxt = S_MEM;
          issue     = 1'b1;
        end
      end
      S_MEM: begin
        // An issued strobe always runs to mem_ack, even if the initiator gave up.
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = (abort_q || !bus.SYNC) ? S_IDLE : S_RPLY;
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_RPLY: begin
        if (!bus.SYNC && !bus.DIN && !bus.DOUT)
          state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (!bus.SYNC)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sync_q     <= 1'b0;
      rd_q       <= 1'b0;
      abort_q    <= 1'b0;
      berr_q     <= 1'b0;
      wait_cnt   <= 4'd0;
      mem_addr   <= 15'd0;
      mem_be     <= 2'b00;
      mem_wdata  <= 16'd0;
      bus.data_o <= 16'd0;
    end else if (ce) begin
      state  <= state_nxt;
      sync_q <= bus.SYNC;
      berr_q <= tmo_hit;
      if (start) begin
        mem_addr <= bus.addr_i[15:1] & MASK[15:1];
        mem_be   <= !bus.WTBT ? 2'b11 : (bus.addr_i[0] ? 2'b10 : 2'b01);
        rd_q     <= bus.DIN;
        abort_q  <= 1'b0;
        wait_cnt <= 4'(WAIT);
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (issue && !rd_q)
        mem_wdata <= bus.data_i;
      if (state == S_MEM && !bus.SYNC)
        abort_q <= 1'b1;
      if (done && rd_q)
        bus.data_o <= mem_rdata;
    end
  end

  assign mem_rd      = (state == S_MEM) && rd_q;
  assign mem_we      = (state == S_MEM) && !rd_q;
  assign bus.RPLY    = (state == S_RPLY);
  assign bus.data_oe = (state == S_RPLY) && rd_q;
  assign bus.berr    = berr_q;

endmodule

// File: tb/tb_busio_target.sv
// Randomized scoreboard bench for busio_target: a driver pushes expected strobes/replies,
// a memory responder answers the local port, and a monitor pops and compares on DUT events.
`timescale 1ns/1ps
module tb_busio_target;
  localparam logic [15:0] BASE   = 16'o100000;
  localparam logic [15:0] MASK   = 16'o077777;
  localparam int          WAIT_C = 3;
  localparam int          TMO_C  = 15;
  localparam int M_NORM = 0, M_ABORT = 1, M_RST = 2, M_CE = 3, M_TMO = 4;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [14:0] mem_addr;
  logic        mem_rd, mem_we, mem_ack;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;

  busio_target_if bus();

  busio_target #(.BASE(BASE), .MASK(MASK), .WAIT(WAIT_C), .TIMEOUT(TMO_C)) dut (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [14:0] waddr; logic [1:0] be; logic [15:0] wdata; int cyc; } strobe_t;
  typedef struct { bit rd; logic [15:0] data; } reply_t;

  strobe_t     sq[$];
  reply_t      rq[$];
  int          bq[$];
  logic [15:0] shadow [int];
  logic [15:0] mem_arr [int];

  int vectors = 0, miscompares = 0;
  int cyc = 0, ack_cyc = 0, ack_wait = 0;
  bit noack = 1'b0;
  logic ack_seen = 1'b0;
  int strobe_cnt = 0, rply_cnt = 0, berr_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  function automatic logic [15:0] init_word(int w);
    return 16'(w * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] shadow_word(int w);
    return shadow.exists(w) ? shadow[w] : init_word(w);
  endfunction

  function automatic logic [15:0] mem_word(int w);
    return mem_arr.exists(w) ? mem_arr[w] : init_word(w);
  endfunction

  always @(posedge clk) begin
    cyc++;
    ack_seen = mem_ack;
  end

  // Local memory device: acks after ack_wait extra strobe cycles, honours byte enables.
  int          rw;
  logic [15:0] rcur;
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if ((mem_rd || mem_we) && !noack) begin
      if (ack_wait > 0) begin
        ack_wait--;
      end else begin
        mem_ack = 1'b1;
        ack_cyc = cyc;
        rw = int'(mem_addr);
        if (mem_we) begin
          rcur = mem_word(rw);
          if (mem_be[0]) rcur[7:0]  = mem_wdata[7:0];
          if (mem_be[1]) rcur[15:8] = mem_wdata[15:8];
          mem_arr[rw] = rcur;
          mem_rdata = 16'hDEAD;
        end else begin
          mem_rdata = mem_word(rw);
        end
      end
    end
  end

  logic    p_str = 1'b0, p_rply = 1'b0, p_berr = 1'b0;
  strobe_t ms;
  reply_t  mr;
  always @(negedge clk) begin
    if ((mem_rd || mem_we) && !p_str) begin
      strobe_cnt++;
      chk("rd_we_exclusive", 32'(mem_rd & mem_we), 32'd0);
      if (sq.size() == 0) flag("unexpected_strobe");
      else begin
        ms = sq.pop_front();
        chk("strobe_dir", 32'(mem_we), 32'(ms.we));
        chk("strobe_time", cyc, ms.cyc);
        chk("mem_addr", 32'(mem_addr), 32'(ms.waddr));
        chk("mem_be", 32'(mem_be), 32'(ms.be));
        if (ms.we) chk("mem_wdata", 32'(mem_wdata), 32'(ms.wdata));
      end
    end
    if (!(mem_rd || mem_we) && p_str && !noack)
      chk("strobe_held_to_ack", 32'(ack_seen), 32'd1);
    if (bus.RPLY && !p_rply) begin
      rply_cnt++;
      if (rq.size() == 0) flag("unexpected_rply");
      else begin
        mr = rq.pop_front();
        chk("rply_after_ack", cyc, ack_cyc + 1);
        chk("data_oe", 32'(bus.data_oe), 32'(mr.rd));
        if (mr.rd) chk("data_o", 32'(bus.data_o), 32'(mr.data));
      end
    end
    if (bus.berr && !p_berr) begin
      berr_cnt++;
      if (bq.size() == 0) flag("unexpected_berr");
      else chk("berr_time", cyc, bq.pop_front());
    end
    p_str  = mem_rd || mem_we;
    p_rply = bus.RPLY;
    p_berr = bus.berr;
  end

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"}, 32'({bus.RPLY, bus.data_oe, bus.berr, mem_rd, mem_we}), 32'd0);
    chk({tag, "_data_o"}, 32'(bus.data_o), 32'd0);
    chk({tag, "_mem_addr_be"}, 32'({mem_addr, mem_be}), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic end_cycle();
    bus.SYNC = 1'b0;
    bus.DIN  = 1'b0;
    bus.DOUT = 1'b0;
  endtask

  task automatic xfer(input bit rd, input bit wtbt, input logic [15:0] addr, input logic [15:0] wd,
                      input int ackd, input int doutd, input int mode);
    bit          hit;
    int          w, k, t, rc0, sc0, bc0;
    strobe_t     s;
    reply_t      r;
    logic [15:0] cur;
    hit = ((addr & ~MASK) == BASE);
    w   = int'((addr & MASK) >> 1);
    @(negedge clk);
    ack_wait = ackd;
    noack    = (mode == M_TMO);
    k   = cyc + 1;
    rc0 = rply_cnt;
    sc0 = strobe_cnt;
    bc0 = berr_cnt;
    if (hit) begin
      s.we    = !rd;
      s.waddr = 15'(w);
      s.be    = !wtbt ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
      s.wdata = wd;
      s.cyc   = (rd || (k + doutd) < (k + WAIT_C + 1)) ? k + WAIT_C + 1 : k + doutd;
      sq.push_back(s);
      if (mode == M_NORM || mode == M_RST || mode == M_CE) begin
        r.rd   = rd;
        r.data = rd ? shadow_word(w) : 16'd0;
        rq.push_back(r);
      end
      if (mode == M_TMO) bq.push_back(s.cyc + TMO_C);
      if (!rd) begin
        cur = shadow_word(w);
        if (!wtbt) cur = wd;
        else if (addr[0]) cur[15:8] = wd[15:8];
        else cur[7:0] = wd[7:0];
        shadow[w] = cur;
      end
    end
    bus.addr_i = addr;
    bus.WTBT   = wtbt;
    bus.data_i = wd;
    bus.DIN    = rd;
    bus.DOUT   = !rd && doutd == 0;
    bus.SYNC   = 1'b1;
    if (!rd) begin
      for (int i = 0; i < doutd; i++) @(negedge clk);
      bus.DOUT = 1'b1;
    end
    if (!hit) begin
      repeat (8) @(negedge clk);
      chk("miss_no_strobe", strobe_cnt - sc0, 0);
      chk("miss_no_rply", rply_cnt - rc0, 0);
      end_cycle();
    end else if (mode == M_ABORT) begin
      t = 0;
      while (!(mem_rd || mem_we) && t < 40) begin @(negedge clk); t++; end
      chk("abort_strobe_seen", 32'(mem_rd | mem_we), 32'd1);
      end_cycle();
      repeat (8) @(negedge clk);
      chk("abort_no_rply", rply_cnt - rc0, 0);
      chk("abort_strobe_count", strobe_cnt - sc0, 1);
      chk("abort_strobe_done", 32'(mem_rd | mem_we), 32'd0);
`ifdef BUSIO_TARGET_TMO_EN
    end else if (mode == M_TMO) begin
      t = 0;
      while (berr_cnt == bc0 && t < 60) begin @(negedge clk); t++; end
      chk("berr_seen", berr_cnt - bc0, 1);
      @(negedge clk);
      chk("berr_width", 32'(bus.berr), 32'd0);
      end_cycle();
      repeat (3) @(negedge clk);
      chk("tmo_no_rply", rply_cnt - rc0, 0);
      noack = 1'b0;
`endif
    end else begin
      t = 0;
      while (!bus.RPLY && t < 60) begin @(negedge clk); t++; end
      chk("rply_seen", 32'(bus.RPLY), 32'd1);
      if (mode == M_RST) begin
        reset = 1'b1;
        @(negedge clk);
        chk_zero("rst_in_rply");
        reset = 1'b0;
        end_cycle();
      end else if (mode == M_CE) begin
        ce = 1'b0;
        end_cycle();
        repeat (3) @(negedge clk);
        chk("ce_freeze_rply", 32'(bus.RPLY), 32'd1);
        ce = 1'b1;
        @(negedge clk);
        chk("rply_clear_after_ce", 32'(bus.RPLY), 32'd0);
      end else begin
        end_cycle();
        @(negedge clk);
        chk("rply_clear", 32'(bus.RPLY), 32'd0);
        chk("oe_clear", 32'(bus.data_oe), 32'd0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int offs[6] = '{0, 1, 2, 3, 16'h3FFE, 16'h3FFF};

  initial begin
    logic [15:0] a;
    bit          rd;
    int          mode;
    reset = 1'b1;
    ce = 1'b0;
    bus.SYNC = 1'b0; bus.DIN = 1'b0; bus.DOUT = 1'b0; bus.WTBT = 1'b0;
    bus.addr_i = 16'd0; bus.data_i = 16'd0;
    mem_ack = 1'b0; mem_rdata = 16'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    ce = 1'b1;
    @(negedge clk);

    xfer(1'b0, 1'b0, 16'o100000, 16'o123456, 0, 0, M_NORM);
    xfer(1'b1, 1'b0, 16'o100000, 16'd0,      0, 0, M_NORM);
    xfer(1'b0, 1'b1, 16'o100001, 16'hAB00,   1, 2, M_NORM);
    xfer(1'b1, 1'b0, 16'o100000, 16'd0,      0, 0, M_NORM);
    xfer(1'b1, 1'b0, 16'o040000, 16'd0,      0, 0, M_NORM);
    xfer(1'b0, 1'b0, 16'o040000, 16'h1234,   0, 0, M_NORM);
    xfer(1'b1, 1'b0, 16'o100002, 16'd0,      2, 0, M_NORM);
    xfer(1'b1, 1'b0, 16'o100004, 16'd0,      3, 0, M_ABORT);
    xfer(1'b1, 1'b1, 16'o100000, 16'd0,      0, 0, M_NORM);
    xfer(1'b1, 1'b0, 16'o100000, 16'd0,      1, 0, M_RST);
    xfer(1'b1, 1'b1, 16'o100001, 16'd0,      1, 0, M_CE);
`ifdef BUSIO_TARGET_TMO_EN
    xfer(1'b1, 1'b0, 16'o100006, 16'd0,      0, 0, M_TMO);
    xfer(1'b1, 1'b0, 16'o100000, 16'd0,      0, 0, M_NORM);
`endif

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = 16'($urandom_range(0, 16'h7FFF));
      else
        a = 16'h8000 | 16'(offs[$urandom_range(0, 5)] << 1) | 16'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      mode = (rd && $urandom_range(0, 15) == 0) ? M_ABORT : M_NORM;
      xfer(rd, 1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3),
           $urandom_range(0, 3), mode);
    end

    repeat (4) @(negedge clk);
    chk("strobe_queue_empty", sq.size(), 0);
    chk("reply_queue_empty", rq.size(), 0);
    chk("berr_queue_empty", bq.size(), 0);
`ifndef BUSIO_TARGET_TMO_EN
    chk("berr_never", berr_cnt, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
